// File: rtl/dp_ram_arbiter.sv
// ---------------------------------------------------------------------------
// dp_ram_arbiter
//   Two-requester round-robin arbiter in front of a simple dual-port RAM
//   (port A read, port B write). Reads and writes are arbitrated
//   independently; each has a 1-bit pointer naming the requester that wins
//   when both ask. Grants are combinational (same cycle as request).
//
//   Handshake: a requester raises req with addr/data/mask and holds them
//   stable until it sees its gnt bit high in the same cycle; the transfer
//   happens in that cycle. Dropping req before a grant abandons the request.
//   Read data comes back one cycle after the grant, flagged by
//   rd_rsp_valid[i]; rd_rsp_data is shared and only meaningful when valid.
//
//   Collision: the selected read and selected write target the same address
//   in the same cycle. Each such cycle bumps coll_cnt (saturating).
//
// Configuration macro:
//   DP_RAM_ARB_COLLISION_STALL_EN - when defined, a colliding read loses its
//   grant for that cycle (write still proceeds, read pointer holds). When not
//   defined, both are granted and the RAM wrapper's write bypass merges data.
//
// Ports:
//   CLKA, rst_n (sync, active-low)
//   rd_req/rd_addr -> rd_gnt, rd_rsp_valid, rd_rsp_data
//   wr_req/wr_addr/wr_data/wr_mask -> wr_gnt
//   ram_CEA/ram_AA, ram_QA : RAM read port
//   ram_CEB/ram_AB/ram_DB/ram_BWB : RAM write port
//   coll_cnt : saturating collision counter
// ---------------------------------------------------------------------------
module dp_ram_arbiter #(
  parameter int ADDR_WIDTH = 8,
  parameter int DATA_WIDTH = 32
) (
  input  logic                    CLKA,
  input  logic                    rst_n,
  input  logic [1:0]              rd_req,
  input  logic [2*ADDR_WIDTH-1:0] rd_addr,
  output logic [1:0]              rd_gnt,
  output logic [1:0]              rd_rsp_valid,
  output logic [DATA_WIDTH-1:0]   rd_rsp_data,
  input  logic [1:0]              wr_req,
  input  logic [2*ADDR_WIDTH-1:0] wr_addr,
  input  logic [2*DATA_WIDTH-1:0] wr_data,
  input  logic [2*DATA_WIDTH-1:0] wr_mask,
  output logic [1:0]              wr_gnt,
  output logic                    ram_CEA,
  output logic [ADDR_WIDTH-1:0]   ram_AA,
  output logic                    ram_CEB,
  output logic [ADDR_WIDTH-1:0]   ram_AB,
  output logic [DATA_WIDTH-1:0]   ram_DB,
  output logic [DATA_WIDTH-1:0]   ram_BWB,
  input  logic [DATA_WIDTH-1:0]   ram_QA,
  output logic [15:0]             coll_cnt
);

  logic        rd_ptr_q, rd_ptr_d;
  logic        wr_ptr_q, wr_ptr_d;
  logic [1:0]  rd_rsp_valid_q, rd_rsp_valid_d;
  logic [15:0] coll_cnt_q, coll_cnt_d;

  logic [1:0]            rd_sel, wr_sel;
  logic [1:0]            rd_gnt_w;
  logic [ADDR_WIDTH-1:0] rd_a, wr_a;
  logic [DATA_WIDTH-1:0] wr_d, wr_m;
  logic                  coll;

  // Priority requester wins if asking, otherwise the other one if asking.
  function automatic logic [1:0] rr_pick(input logic [1:0] req, input logic ptr);
    logic [1:0] g;
    g = '0;
    if (req[ptr])       g[ptr]  = 1'b1;
    else if (req[~ptr]) g[~ptr] = 1'b1;
    return g;
  endfunction

  always_comb begin
    // Selection is suppressed during reset so no grant or collision appears.
    rd_sel = rst_n ? rr_pick(rd_req, rd_ptr_q) : 2'b00;
    wr_sel = rst_n ? rr_pick(wr_req, wr_ptr_q) : 2'b00;

    rd_a = rd_sel[1] ? rd_addr[2*ADDR_WIDTH-1:ADDR_WIDTH] : rd_addr[ADDR_WIDTH-1:0];
    wr_a = wr_sel[1] ? wr_addr[2*ADDR_WIDTH-1:ADDR_WIDTH] : wr_addr[ADDR_WIDTH-1:0];
    wr_d = wr_sel[1] ? wr_data[2*DATA_WIDTH-1:DATA_WIDTH] : wr_data[DATA_WIDTH-1:0];
    wr_m = wr_sel[1] ? wr_mask[2*DATA_WIDTH-1:DATA_WIDTH] : wr_mask[DATA_WIDTH-1:0];

    coll = (|rd_sel) && (|wr_sel) && (rd_a == wr_a);

`ifdef DP_RAM_ARB_COLLISION_STALL_EN
    rd_gnt_w = coll ? 2'b00 : rd_sel;
`else
    rd_gnt_w = rd_sel;
`endif

    // After a grant the pointer names the non-granted requester:
    // granted 0 -> pointer 1, granted 1 -> pointer 0.
    rd_ptr_d = (|rd_gnt_w) ? rd_gnt_w[0] : rd_ptr_q;
    wr_ptr_d = (|wr_sel)   ? wr_sel[0]   : wr_ptr_q;

    rd_rsp_valid_d = rd_gnt_w;

    coll_cnt_d = coll_cnt_q;
    if (coll && (coll_cnt_q != 16'hFFFF)) coll_cnt_d = coll_cnt_q + 16'd1;
  end

  always_ff @(posedge CLKA) begin
    if (!rst_n) begin
      rd_ptr_q       <= 1'b0;
      wr_ptr_q       <= 1'b0;
      rd_rsp_valid_q <= 2'b00;
      coll_cnt_q     <= 16'd0;
    end else begin
      rd_ptr_q       <= rd_ptr_d;
      wr_ptr_q       <= wr_ptr_d;
      rd_rsp_valid_q <= rd_rsp_valid_d;
      coll_cnt_q     <= coll_cnt_d;
    end
  end

  assign rd_gnt  = rd_gnt_w;
  assign wr_gnt  = wr_sel;
  assign ram_CEA = |rd_gnt_w;
  assign ram_AA  = (|rd_gnt_w) ? rd_a : '0;
  assign ram_CEB = |wr_sel;
  assign ram_AB  = (|wr_sel) ? wr_a : '0;
  assign ram_DB  = (|wr_sel) ? wr_d : '0;
  assign ram_BWB = (|wr_sel) ? wr_m : '0;

  // A response pending when reset arrives is masked immediately, so a read
  // granted just before reset never shows a valid.
  assign rd_rsp_valid = rd_rsp_valid_q & {2{rst_n}};
  assign rd_rsp_data  = ram_QA;
  assign coll_cnt     = coll_cnt_q;

endmodule

// File: tb/tb_dp_ram_arbiter.sv
// ---------------------------------------------------------------------------
// tb_dp_ram_arbiter
//   Bench for dp_ram_arbiter: a behavioural RAM drives ram_QA from the DUT's
//   RAM port outputs; a reference model built from the arbitration rules
//   (priority index, memory array, expected response) predicts every output.
//   Honours DP_RAM_ARB_COLLISION_STALL_EN the same way as the design.
// ---------------------------------------------------------------------------
module tb_dp_ram_arbiter;
  localparam int AW = 8;
  localparam int DW = 32;

  // ---------------- clock / reset ----------------
  logic CLKA = 1'b0;
  always #5 CLKA = ~CLKA;
  logic rst_n = 1'b0;

  // ---------------- DUT signals ----------------
  logic [1:0]      rd_req = '0;
  logic [2*AW-1:0] rd_addr = '0;
  logic [1:0]      rd_gnt, rd_rsp_valid;
  logic [DW-1:0]   rd_rsp_data;
  logic [1:0]      wr_req = '0;
  logic [2*AW-1:0] wr_addr = '0;
  logic [2*DW-1:0] wr_data = '0;
  logic [2*DW-1:0] wr_mask = '0;
  logic [1:0]      wr_gnt;
  logic            ram_CEA, ram_CEB;
  logic [AW-1:0]   ram_AA, ram_AB;
  logic [DW-1:0]   ram_DB, ram_BWB;
  logic [DW-1:0]   ram_QA = '0;
  logic [15:0]     coll_cnt;

  dp_ram_arbiter #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW)) dut (
    .CLKA(CLKA), .rst_n(rst_n),
    .rd_req(rd_req), .rd_addr(rd_addr), .rd_gnt(rd_gnt),
    .rd_rsp_valid(rd_rsp_valid), .rd_rsp_data(rd_rsp_data),
    .wr_req(wr_req), .wr_addr(wr_addr), .wr_data(wr_data), .wr_mask(wr_mask),
    .wr_gnt(wr_gnt),
    .ram_CEA(ram_CEA), .ram_AA(ram_AA),
    .ram_CEB(ram_CEB), .ram_AB(ram_AB), .ram_DB(ram_DB), .ram_BWB(ram_BWB),
    .ram_QA(ram_QA), .coll_cnt(coll_cnt)
  );

  // ---------------- RAM behaviour (environment) ----------------
  logic [DW-1:0] env_mem [256];
  always @(posedge CLKA) begin
    if (ram_CEA)
      ram_QA <= (ram_CEB && ram_AB == ram_AA) ?
                ((ram_DB & ram_BWB) | (env_mem[ram_AA] & ~ram_BWB)) : env_mem[ram_AA];
    if (ram_CEB)
      env_mem[ram_AB] <= (ram_DB & ram_BWB) | (env_mem[ram_AB] & ~ram_BWB);
  end

  // ---------------- reference model state ----------------
  int            rd_prio, wr_prio, m_cnt;
  logic [1:0]    m_valid;
  logic [DW-1:0] m_data;
  logic [DW-1:0] m_mem [256];
  logic [DW-1:0] exp_q [$];   // expected read data, oldest first

  // Observed values captured by the most recent step
  logic [1:0]    obs_rd_gnt, obs_wr_gnt, obs_valid;
  logic [AW-1:0] obs_ab;
  logic [DW-1:0] obs_data;
  logic [15:0]   obs_cnt;

  int n_checks = 0;
  int n_fail   = 0;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic int pick(input logic [1:0] req, input int prio);
    if (req[prio])     return prio;
    if (req[1 - prio]) return 1 - prio;
    return -1;
  endfunction

  // One clock cycle. Called just after a falling edge with inputs already
  // driven; checks outputs, advances the model, returns after next fall.
  task automatic step(input bit do_chk);
    int            rs, ws;
    logic          coll;
    logic [AW-1:0] ra, wa;
    logic [DW-1:0] wd, wm, merged, qd;
    logic [1:0]    eg_r, eg_w;
    #2;
    rs = -1; ws = -1; coll = 1'b0; ra = '0; wa = '0; wd = '0; wm = '0;
    if (rst_n) begin
      rs = pick(rd_req, rd_prio);
      ws = pick(wr_req, wr_prio);
      if (rs >= 0) ra = rd_addr[rs*AW +: AW];
      if (ws >= 0) begin
        wa = wr_addr[ws*AW +: AW];
        wd = wr_data[ws*DW +: DW];
        wm = wr_mask[ws*DW +: DW];
      end
      coll = (rs >= 0) && (ws >= 0) && (ra == wa);
`ifdef DP_RAM_ARB_COLLISION_STALL_EN
      if (coll) rs = -1;
`endif
    end
    eg_r = '0; if (rs >= 0) eg_r[rs] = 1'b1;
    eg_w = '0; if (ws >= 0) eg_w[ws] = 1'b1;

    obs_rd_gnt = rd_gnt; obs_wr_gnt = wr_gnt; obs_valid = rd_rsp_valid;
    obs_ab = ram_AB; obs_data = rd_rsp_data; obs_cnt = coll_cnt;

    if (do_chk) begin
      chk("rd_gnt",  rd_gnt,  eg_r);
      chk("wr_gnt",  wr_gnt,  eg_w);
      chk("ram_CEA", ram_CEA, rs >= 0);
      chk("ram_AA",  ram_AA,  (rs >= 0) ? ra : '0);
      chk("ram_CEB", ram_CEB, ws >= 0);
      chk("ram_AB",  ram_AB,  wa);
      chk("ram_DB",  ram_DB,  wd);
      chk("ram_BWB", ram_BWB, wm);
      chk("rd_rsp_valid", rd_rsp_valid, rst_n ? m_valid : 2'b00);
      if (rst_n && m_valid != 2'b00) chk("rd_rsp_data", rd_rsp_data, m_data);
      chk("coll_cnt", coll_cnt, m_cnt);
    end

    if (!rst_n) begin
      rd_prio = 0; wr_prio = 0; m_valid = '0; m_cnt = 0;
    end else begin
      m_valid = eg_r;
      merged = (wd & wm) | (m_mem[wa] & ~wm);
      if (rs >= 0) begin
        qd = (ws >= 0 && wa == ra) ? merged : m_mem[ra];
        m_data = qd;
        exp_q.push_back(qd);
        rd_prio = 1 - rs;
      end
      if (ws >= 0) begin
        m_mem[wa] = merged;
        wr_prio = 1 - ws;
      end
      if (coll && m_cnt < 65535) m_cnt++;
    end
    @(negedge CLKA);
  endtask

  // Random-phase requester state (holds until granted)
  logic [1:0] rd_pend, wr_pend;
  logic [1:0] seq_exp [4];
  int         gnt_cycle, valid_cycle;
  logic [DW-1:0] got_data;

`ifdef DP_RAM_ARB_COLLISION_STALL_EN
  localparam int EXP_GNT_CYCLE = 1;
`else
  localparam int EXP_GNT_CYCLE = 0;
`endif

  initial begin
    for (int i = 0; i < 256; i++) begin env_mem[i] = '0; m_mem[i] = '0; end
    rd_prio = 0; wr_prio = 0; m_cnt = 0; m_valid = '0; m_data = '0;
    seq_exp[0] = 2'b01; seq_exp[1] = 2'b10; seq_exp[2] = 2'b01; seq_exp[3] = 2'b10;

    // ---- reset with requests asserted: no grants allowed ----
    @(negedge CLKA);
    rd_req = 2'b11; wr_req = 2'b11; rd_addr = {8'h02, 8'h01}; wr_addr = {8'h04, 8'h03};
    step(1); step(1);
    rst_n = 1'b1; rd_req = '0; wr_req = '0;
    step(1);

    // ---- read round-robin with both requesters asking for 4 cycles ----
    rd_req = 2'b11; rd_addr = {8'h22, 8'h11};
    for (int k = 0; k < 5; k++) begin
      if (k == 4) rd_req = 2'b00;
      step(1);
      if (k < 4) chk("rr_rd_gnt_seq", obs_rd_gnt, seq_exp[k]);
      if (k > 0) chk("rr_rsp_valid_seq", obs_valid, seq_exp[k-1]);
    end
    step(1);

    // ---- write round-robin: addr 0x10 then 0x20 ----
    wr_req = 2'b11; wr_addr = {8'h20, 8'h10};
    wr_data = {32'h2222_2222, 32'h1111_1111}; wr_mask = '1;
    step(1);
    chk("wr_seq_gnt0", obs_wr_gnt, 2'b01);
    chk("wr_seq_ab0",  obs_ab,     8'h10);
    wr_req = 2'b10;
    step(1);
    chk("wr_seq_gnt1", obs_wr_gnt, 2'b10);
    chk("wr_seq_ab1",  obs_ab,     8'h20);
    wr_req = 2'b00;
    step(1);

    // ---- read/write collision at 0x05 ----
    rst_n = 1'b0; step(1); rst_n = 1'b1;
    rd_req = 2'b01; rd_addr = {8'h00, 8'h05};
    wr_req = 2'b01; wr_addr = {8'h00, 8'h05};
    wr_data = {32'h0, 32'hA5A5_A5A5}; wr_mask = {32'h0, 32'hFFFF_FFFF};
    gnt_cycle = -1; valid_cycle = -1; got_data = '0;
    for (int k = 0; k < 4; k++) begin
      step(1);
      wr_req = 2'b00;
      if (obs_valid[0] && valid_cycle < 0) begin valid_cycle = k; got_data = obs_data; end
      if (obs_rd_gnt[0] && gnt_cycle < 0) begin gnt_cycle = k; rd_req = 2'b00; end
    end
    chk("coll_cnt_one", obs_cnt, 16'd1);
    chk("coll_rd_gnt_cycle", gnt_cycle, EXP_GNT_CYCLE);
    chk("coll_rsp_cycle", valid_cycle, EXP_GNT_CYCLE + 1);
    chk("coll_rsp_data", got_data, 32'hA5A5_A5A5);

    // ---- reset in the cycle after a read grant ----
    rd_req = 2'b01; wr_req = 2'b01; rd_addr = {8'h00, 8'h07}; wr_addr = {8'h00, 8'h08};
    step(1);
    chk("pre_rst_rd_gnt", obs_rd_gnt, 2'b01);
    rst_n = 1'b0; rd_req = '0; wr_req = '0;
    step(1);
    chk("rst_valid_masked", obs_valid, 2'b00);
    step(1);
    rst_n = 1'b1;
    step(1);
    chk("post_rst_valid", obs_valid, 2'b00);
    chk("post_rst_cnt",   obs_cnt,   16'd0);
    rd_req = 2'b11; wr_req = 2'b11; rd_addr = {8'h31, 8'h30}; wr_addr = {8'h41, 8'h40};
    step(1);
    chk("post_rst_rd_ptr", obs_rd_gnt, 2'b01);
    chk("post_rst_wr_ptr", obs_wr_gnt, 2'b01);
    rd_req = '0; wr_req = '0;
    step(1);

    // ---- random traffic, requesters honour hold-until-granted ----
    rd_pend = '0; wr_pend = '0;
    for (int c = 0; c < 600; c++) begin
      for (int i = 0; i < 2; i++) begin
        if (!rd_pend[i] && $urandom_range(0, 2) != 0) begin
          rd_pend[i] = 1'b1;
          rd_addr[i*AW +: AW] = AW'($urandom_range(0, 7));
        end
        if (!wr_pend[i] && $urandom_range(0, 2) != 0) begin
          wr_pend[i] = 1'b1;
          wr_addr[i*AW +: AW] = AW'($urandom_range(0, 7));
          wr_data[i*DW +: DW] = $urandom;
          wr_mask[i*DW +: DW] = ($urandom_range(0, 1) != 0) ? '1 : DW'($urandom);
        end
      end
      rd_req = rd_pend; wr_req = wr_pend;
      step(1);
      rd_pend = rd_pend & ~obs_rd_gnt;
      wr_pend = wr_pend & ~obs_wr_gnt;
    end
    rd_req = '0; wr_req = '0;
    step(1);

    // ---- collision counter saturation ----
    rst_n = 1'b0; step(1); rst_n = 1'b1;
    rd_req = 2'b01; rd_addr = {8'h00, 8'h03};
    wr_req = 2'b01; wr_addr = {8'h00, 8'h03}; wr_data = '0; wr_mask = '1;
    for (int k = 0; k < 65540; k++) step(0);
    rd_req = '0; wr_req = '0;
    step(1);
    chk("coll_cnt_sat", obs_cnt, 16'hFFFF);
    step(1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
